pkt_bank_scheduler: RTL and testbench

//  Multi-bank packet-buffer scheduler between the frontend (BRAM writer) and the backend engine (start/finish).

---
 rtl/pkt_bank_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_pkt_bank_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_bank_scheduler.sv
// Multi-bank packet-buffer scheduler: hands free banks to the frontend,
// queues filled banks in FIFO order and runs them through the backend engine.
module pkt_bank_scheduler #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic              aclk,
    input  logic              areset,
    output logic              fe_grant,
    output logic [BANK_W-1:0] fe_bank,
    input  logic              fe_done,
    input  logic [15:0]       fe_length,
    output logic              be_start,
    output logic [BANK_W-1:0] be_bank,
    output logic [15:0]       be_length,
    input  logic              be_finish,
    output logic              be_abort,
    output logic [BANK_W:0]   occupancy,
    output logic [31:0]       pkt_cnt,
    output logic [15:0]       drop_cnt,
    output logic              err_ovf,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [BANK_W:0] OCC_FULL = (BANK_W + 1)'(NUM_BANKS);

    typedef enum logic {
        BE_IDLE,
        BE_WAIT
    } be_state_e;

    be_state_e state_q, state_d;

    logic [BANK_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [BANK_W:0]   occ_q, occ_d;
    logic [15:0]       len_q [NUM_BANKS];

    logic              be_start_q, be_start_d;
    logic              be_abort_q, be_abort_d;
    logic [BANK_W-1:0] be_bank_q, be_bank_d;
    logic [15:0]       be_length_q, be_length_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_spurious_q, err_spurious_d;

    logic grant;
    logic accept;
    logic drop;
    logic release_bank;
    logic finish_ok;
    logic timed_out;
    logic spurious;

    // Frontend side: a full queue turns fe_done into an overflow drop,
    // even when a bank is released in that same cycle.
    always_comb begin
        grant  = (occ_q != OCC_FULL);
        accept = fe_done && grant && (fe_length != 16'd0);
        drop   = fe_done && (!grant || (fe_length == 16'd0));
    end

    always_comb begin
        state_d      = state_q;
        be_start_d   = 1'b0;
        be_abort_d   = 1'b0;
        be_bank_d    = be_bank_q;
        be_length_d  = be_length_q;
        wdog_d       = wdog_q;
        release_bank = 1'b0;
        finish_ok    = 1'b0;
        timed_out    = 1'b0;
        spurious     = 1'b0;
        unique case (state_q)
            BE_IDLE: begin
                spurious = be_finish;
                if (occ_q != '0) begin
                    be_start_d  = 1'b1;
                    be_bank_d   = rd_ptr_q;
                    be_length_d = len_q[rd_ptr_q];
                    wdog_d      = '0;
                    state_d     = BE_WAIT;
                end
            end
            BE_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (be_finish) begin
                    release_bank = 1'b1;
                    finish_ok    = 1'b1;
                    state_d      = BE_IDLE;
                end else if (wdog_q == WD_LAST) begin
                    release_bank = 1'b1;
                    timed_out    = 1'b1;
                    be_abort_d   = 1'b1;
                    state_d      = BE_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + BANK_W'(1);
        end
        if (release_bank) begin
            rd_ptr_d = rd_ptr_q + BANK_W'(1);
        end
        unique case ({accept, release_bank})
            2'b10:   occ_d = occ_q + (BANK_W + 1)'(1);
            2'b01:   occ_d = occ_q - (BANK_W + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        pkt_cnt_d      = pkt_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        err_ovf_d      = err_ovf_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q;
        if (finish_ok) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (fe_done && !grant) begin
            err_ovf_d = 1'b1;
        end
        if (timed_out) begin
            err_timeout_d = 1'b1;
        end
        if (spurious) begin
            err_spurious_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= BE_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            be_start_q     <= 1'b0;
            be_abort_q     <= 1'b0;
            be_bank_q      <= '0;
            be_length_q    <= '0;
            wdog_q         <= '0;
            pkt_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            err_ovf_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            be_start_q     <= be_start_d;
            be_abort_q     <= be_abort_d;
            be_bank_q      <= be_bank_d;
            be_length_q    <= be_length_d;
            wdog_q         <= wdog_d;
            pkt_cnt_q      <= pkt_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_ovf_q      <= err_ovf_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
            if (accept) begin
                len_q[wr_ptr_q] <= fe_length;
            end
        end
    end

    assign fe_grant     = grant;
    assign fe_bank      = wr_ptr_q;
    assign be_start     = be_start_q;
    assign be_bank      = be_bank_q;
    assign be_length    = be_length_q;
    assign be_abort     = be_abort_q;
    assign occupancy    = occ_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign drop_cnt     = drop_cnt_q;
    assign err_ovf      = err_ovf_q;
    assign err_timeout  = err_timeout_q;
    assign err_spurious = err_spurious_q;

endmodule

// File: tb/tb_pkt_bank_scheduler.sv
// Directed bench for pkt_bank_scheduler: queue-level reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_pkt_bank_scheduler;

    localparam int NB = 2;
    localparam int BW = 1;
    localparam int TO = 16;

    logic          clk;
    logic          areset;
    logic          fe_grant;
    logic [BW-1:0] fe_bank;
    logic          fe_done;
    logic [15:0]   fe_length;
    logic          be_start;
    logic [BW-1:0] be_bank;
    logic [15:0]   be_length;
    logic          be_finish;
    logic          be_abort;
    logic [BW:0]   occupancy;
    logic [31:0]   pkt_cnt;
    logic [15:0]   drop_cnt;
    logic          err_ovf;
    logic          err_timeout;
    logic          err_spurious;

    int total = 0;
    int bad   = 0;

    pkt_bank_scheduler #(
        .NUM_BANKS(NB),
        .BANK_W   (BW),
        .TIMEOUT  (TO)
    ) dut (
        .aclk        (clk),
        .areset      (areset),
        .fe_grant    (fe_grant),
        .fe_bank     (fe_bank),
        .fe_done     (fe_done),
        .fe_length   (fe_length),
        .be_start    (be_start),
        .be_bank     (be_bank),
        .be_length   (be_length),
        .be_finish   (be_finish),
        .be_abort    (be_abort),
        .occupancy   (occupancy),
        .pkt_cnt     (pkt_cnt),
        .drop_cnt    (drop_cnt),
        .err_ovf     (err_ovf),
        .err_timeout (err_timeout),
        .err_spurious(err_spurious)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: filled banks as a FIFO of lengths, backend as a
    // busy flag plus the edge count at which the current job started.
    int unsigned mq[$];
    int          m_wr, m_rd, m_bank;
    int unsigned m_len, m_pkt, m_drop;
    bit          m_busy, m_start, m_abort, m_ovf, m_to, m_spur;
    bit          live = 1'b0;
    longint      cyc = 0;
    longint      t_start = 0;

    always @(posedge clk) begin
        bit rel;
        bit full;
        cyc++;
        if (areset) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_bank = 0; m_len = 0;
            m_pkt = 0; m_drop = 0; m_busy = 0;
            m_start = 0; m_abort = 0;
            m_ovf = 0; m_to = 0; m_spur = 0;
            live = 1'b1;
        end else begin
            rel     = 1'b0;
            full    = (mq.size() == NB);
            m_start = 1'b0;
            m_abort = 1'b0;
            if (!m_busy) begin
                if (be_finish) m_spur = 1'b1;
                if (mq.size() > 0) begin
                    m_start = 1'b1;
                    m_busy  = 1'b1;
                    t_start = cyc;
                    m_bank  = m_rd;
                    m_len   = mq[0];
                end
            end else if (be_finish) begin
                rel    = 1'b1;
                m_pkt  = m_pkt + 1;
                m_busy = 1'b0;
            end else if (cyc - t_start == TO) begin
                rel     = 1'b1;
                m_abort = 1'b1;
                m_to    = 1'b1;
                m_busy  = 1'b0;
            end
            if (fe_done) begin
                if (full) begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end else if (fe_length == 16'd0) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back(fe_length);
                    m_wr = (m_wr + 1) % NB;
                end
            end
            if (rel) begin
                void'(mq.pop_front());
                m_rd = (m_rd + 1) % NB;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("fe_grant", fe_grant, (mq.size() != NB));
            chk("fe_bank", fe_bank, m_wr);
            chk("occupancy", occupancy, mq.size());
            chk("be_start", be_start, m_start);
            chk("be_bank", be_bank, m_bank);
            chk("be_length", be_length, m_len);
            chk("be_abort", be_abort, m_abort);
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_timeout", err_timeout, m_to);
            chk("err_spurious", err_spurious, m_spur);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        areset    = 1'b1;
        fe_done   = 1'b0;
        fe_length = 16'd0;
        be_finish = 1'b0;
        step(2);
        areset = 1'b0;
        chk("rst_grant", fe_grant, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_bank", fe_bank, 0);
        step(3);

        // single packet, start two cycles after fe_done
        fe_done = 1'b1; fe_length = 16'd60;
        step;
        fe_done = 1'b0;
        chk("t1_start_early", be_start, 0);
        chk("t1_occ", occupancy, 1);
        step;
        chk("t1_start", be_start, 1);
        chk("t1_bank", be_bank, 0);
        chk("t1_len", be_length, 60);
        be_finish = 1'b1;
        step;
        be_finish = 1'b0;
        chk("t1_pkt", pkt_cnt, 1);
        chk("t1_occ0", occupancy, 0);
        step(2);

        // fill both banks, third fe_done overflows
        areset = 1'b1;
        step;
        areset = 1'b0;
        fe_done = 1'b1; fe_length = 16'd1514;
        step;
        fe_length = 16'd800;
        step;
        fe_length = 16'd5;
        step;
        fe_done = 1'b0;
        chk("t2_occ", occupancy, 2);
        chk("t2_grant", fe_grant, 0);
        chk("t2_ovf", err_ovf, 1);
        chk("t2_drop", drop_cnt, 1);
        chk("t2_len", be_length, 1514);

        // release while full still drops the new fe_done
        be_finish = 1'b1; fe_done = 1'b1; fe_length = 16'd7;
        step;
        be_finish = 1'b0; fe_done = 1'b0;
        chk("t3_occ", occupancy, 1);
        chk("t3_drop", drop_cnt, 2);
        step;
        chk("t3_start", be_start, 1);
        chk("t3_bank", be_bank, 1);
        chk("t3_len", be_length, 800);

        // accept and release in the same cycle
        be_finish = 1'b1; fe_done = 1'b1; fe_length = 16'd300;
        step;
        be_finish = 1'b0; fe_done = 1'b0;
        chk("t3b_occ", occupancy, 1);
        chk("t3b_pkt", pkt_cnt, 2);
        chk("t3b_febank", fe_bank, 1);
        step;
        chk("t3b_start", be_start, 1);
        chk("t3b_bank", be_bank, 0);
        chk("t3b_len", be_length, 300);

        // watchdog
        for (int i = 1; i < TO; i++) begin
            step;
            chk("t4_abort_early", be_abort, 0);
        end
        step;
        chk("t4_abort", be_abort, 1);
        chk("t4_to", err_timeout, 1);
        chk("t4_occ", occupancy, 0);
        step;
        chk("t4_abort_pulse", be_abort, 0);

        // zero length and spurious finish
        fe_done = 1'b1; fe_length = 16'd0;
        step;
        fe_done = 1'b0;
        chk("t5_drop", drop_cnt, 3);
        step(3);
        chk("t5_nostart", be_start, 0);
        chk("t5_occ", occupancy, 0);
        be_finish = 1'b1;
        step;
        be_finish = 1'b0;
        chk("t5_spur", err_spurious, 1);
        chk("t5_pkt", pkt_cnt, 2);

        // reset in the middle of a job with both banks full
        fe_done = 1'b1; fe_length = 16'd100;
        step;
        fe_length = 16'd200;
        step;
        fe_done = 1'b0;
        step;
        chk("t6_occ_pre", occupancy, 2);
        areset = 1'b1;
        step;
        areset = 1'b0;
        chk("t6_occ", occupancy, 0);
        chk("t6_start", be_start, 0);
        chk("t6_grant", fe_grant, 1);
        chk("t6_ovf", err_ovf, 0);
        chk("t6_to", err_timeout, 0);
        chk("t6_spur", err_spurious, 0);
        chk("t6_drop", drop_cnt, 0);
        step(3);
        chk("t6_nostart", be_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
